// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The loader takes the slave view; the stream source / memory model takes the master view.
interface imem_loader_if #(
    parameter int OP_LENGTH = 32,
    parameter int PC_WIDTH  = 12
);
    logic [7:0]           byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 imem_we;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic [OP_LENGTH-1:0] imem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a counted little-endian byte stream into instruction words,
// writes them from address 0 and holds the CPU in reset until the image is in memory.
module imem_loader #(
    parameter int OP_LENGTH = 32,
    parameter int PC_WIDTH  = 12
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** (PC_WIDTH - 2));

    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE, ERROR} state_t;

    state_t               state, state_nx;
    logic [15:0]          cnt;
    logic [15:0]          widx;
    logic [1:0]           bcnt;
    logic [OP_LENGTH-9:0] shreg;
    logic                 last_p1;
    logic                 byte_ready;
    logic                 accept;
    logic [15:0]          n_full;
    logic                 imem_we;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic [OP_LENGTH-1:0] imem_wdata;

    assign accept = bus.byte_valid && byte_ready;
    assign n_full = {bus.byte_in, cnt[7:0]};

    assign bus.byte_ready = byte_ready;
    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = imem_addr;
    assign bus.imem_wdata = imem_wdata;

    always_ff @(posedge clk) begin
        if (!rst) state <= HDR_LO;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            HDR_LO: begin
                byte_ready = 1'b1;
                if (bus.byte_valid) state_nx = HDR_HI;
            end
            HDR_HI: begin
                byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    if (n_full == 16'd0)                 state_nx = DONE;
                    else if ({1'b0, n_full} > MAX_WORDS) state_nx = ERROR;
                    else                                 state_nx = DATA;
                end
            end
            DATA: begin
                // The final word's write cycle takes no more bytes; release follows it.
                byte_ready = !last_p1;
                if (last_p1) state_nx = DONE;
            end
            DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            ERROR: begin
                err = 1'b1;
            end
            default: state_nx = HDR_LO;
        endcase
    end

    // Word assembly stage: the 4th byte launches the write on the next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            widx       <= '0;
            bcnt       <= '0;
            last_p1    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            last_p1 <= 1'b0;
            if (accept) begin
                case (state)
                    HDR_LO: cnt[7:0]  <= bus.byte_in;
                    HDR_HI: cnt[15:8] <= bus.byte_in;
                    DATA: begin
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {bus.byte_in, shreg};
                            imem_addr  <= PC_WIDTH'({widx, 2'b00});
                            widx       <= widx + 16'd1;
                            last_p1    <= (widx + 16'd1 == cnt);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && state == DATA && bcnt != 2'd3)
            shreg <= {bus.byte_in, shreg[OP_LENGTH-9:8]};
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a write scoreboard checked by an independent monitor,
// plus cycle-exact checks of reset, release and error behaviour.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_rst, done, err;

    imem_loader_if #(.OP_LENGTH(32), .PC_WIDTH(12)) bus ();

    imem_loader #(.OP_LENGTH(32), .PC_WIDTH(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [11:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every write the DUT issues must match the head of the scoreboard.
    initial begin
        wr_t w;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("done_err_exclusive", {31'd0, done & err}, 32'd0);
            if (bus.imem_we === 1'b1) begin
                check("cpu_rst_during_write", {31'd0, cpu_rst}, 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h expected no write",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    w = exp_q.pop_front();
                    check("write_addr", {20'd0, bus.imem_addr}, {20'd0, w.a});
                    check("write_data", bus.imem_wdata, w.d);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int cycles);
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        rst = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("byte_accept_in_time", {31'd0, bus.byte_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Called in the cycle right after the final data byte was taken.
    task automatic check_release(input string nm);
        check({nm, "_we_last"},     {31'd0, bus.imem_we}, 32'd1);
        check({nm, "_rst_at_W"},    {31'd0, cpu_rst}, 32'd1);
        check({nm, "_done_at_W"},   {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        check({nm, "_cpu_rst"},     {31'd0, cpu_rst}, 32'd0);
        check({nm, "_done"},        {31'd0, done}, 32'd1);
        check({nm, "_ready"},       {31'd0, bus.byte_ready}, 32'd0);
        check({nm, "_err"},         {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        check({nm, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0]  tb_bytes [4];
        logic        tog [7];
        logic [31:0] w;
        int          ptr;

        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;

        // Idle after reset.
        do_reset(3);
        for (int i = 0; i < 5; i++) begin
            check("idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            check("idle_ready",   {31'd0, bus.byte_ready}, 32'd1);
            check("idle_done",    {31'd0, done}, 32'd0);
            check("idle_we",      {31'd0, bus.imem_we}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Two-word image with continuous valid.
        expect_wr(12'h000, 32'h0010_0513);
        expect_wr(12'h004, 32'h0020_0593);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h0010_0513);
        send_word(32'h0020_0593);
        check_release("two_word");

        // Empty image releases right after the header; later bytes are refused.
        do_reset(1);
        send_byte(8'h00);
        send_byte(8'h00);
        check("empty_done",    {31'd0, done}, 32'd1);
        check("empty_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        bus.byte_in    = 8'h55;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("empty_refuse", {31'd0, bus.byte_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;

        // Oversized header.
        do_reset(1);
        send_byte(8'h01);
        send_byte(8'h04);
        bus.byte_in    = 8'hAA;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_err",     {31'd0, err}, 32'd1);
            check("ovf_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            check("ovf_ready",   {31'd0, bus.byte_ready}, 32'd0);
            check("ovf_done",    {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;

        // Full-capacity image: 1024 words, last address 0xFFC.
        do_reset(1);
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 1024; i++) begin
            w = 32'h9E37_79B9 * (i + 1);
            expect_wr(12'(i * 4), w);
            send_word(w);
        end
        check_release("full");

        // Gappy valid: 1,0,0,1,0,1,1 carries the four bytes of one word.
        do_reset(1);
        expect_wr(12'h000, 32'h1234_5678);
        send_byte(8'h01);
        send_byte(8'h00);
        tb_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
        tog      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ptr = 0;
        for (int k = 0; k < 7; k++) begin
            bus.byte_valid = tog[k];
            bus.byte_in    = tog[k] ? tb_bytes[ptr] : 8'hFF;
            @(posedge clk);
            #1;
            if (tog[k]) ptr++;
        end
        bus.byte_valid = 1'b0;
        check_release("gappy");

        // Reset mid-word, then a fresh stream.
        do_reset(1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset(1);
        check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("midrst_ready",   {31'd0, bus.byte_ready}, 32'd1);
        check("midrst_addr",    {20'd0, bus.imem_addr}, 32'd0);
        expect_wr(12'h000, 32'hDEAD_BEEF);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hDEAD_BEEF);
        check_release("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
